// File: rtl/key_repeat_debounce.sv
// Per-channel key debouncer with auto-repeat: a held key pulses after DELAY+1 samples, then repeats with the interval halving up to MAX_STEPS times.
// Optional macro DEBOUNCE_SYNC_EN inserts a 2-flop synchroniser on every noisy bit ahead of the FSMs.
module key_repeat_debounce #(
  parameter int CHANNELS  = 4,
  parameter int DELAY     = 100000000,
  parameter int MAX_STEPS = 7,
  parameter int CNT_W     = 28
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] noisy,
  output logic [CHANNELS-1:0] clean,
  output logic [CHANNELS-1:0] held,
  output logic [CHANNELS-1:0] fast
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    REPEAT = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] DELAY_C = CNT_W'(DELAY);
  localparam logic [3:0]       MAX_C   = 4'(MAX_STEPS);

  logic [CHANNELS-1:0] sample;

`ifdef DEBOUNCE_SYNC_EN
  logic [CHANNELS-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= noisy;
      sync2_q <= sync1_q;
    end
  end

  assign sample = sync2_q;
`else
  assign sample = noisy;
`endif

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] interval_q, interval_d;
    logic [3:0]       step_q, step_d;
    logic             clean_q, clean_d;
    logic             held_q, held_d;
    logic             fast_q, fast_d;

    always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      interval_d = interval_q;
      step_d     = step_q;
      clean_d    = 1'b0;
      held_d     = held_q;
      fast_d     = fast_q;
      if (!sample[g]) begin
        // Any low sample abandons the press; the next press starts from scratch.
        state_d    = IDLE;
        count_d    = '0;
        interval_d = DELAY_C;
        step_d     = '0;
        held_d     = 1'b0;
        fast_d     = 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            state_d    = ARM;
            count_d    = CNT_W'(1);
            interval_d = DELAY_C;
            step_d     = '0;
            held_d     = 1'b0;
            fast_d     = 1'b0;
          end
          default: begin
            if (count_q == interval_q) begin
              clean_d = 1'b1;
              count_d = '0;
              state_d = REPEAT;
              held_d  = 1'b1;
              if (step_q < MAX_C) begin
                interval_d = interval_q >> 1;
                step_d     = step_q + 4'd1;
              end
            end else begin
              count_d = count_q + CNT_W'(1);
            end
            // Uses the pre-update step so fast trails the step change by a cycle.
            fast_d = held_d && (step_q == MAX_C);
          end
        endcase
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q    <= IDLE;
        count_q    <= '0;
        interval_q <= DELAY_C;
        step_q     <= '0;
        clean_q    <= 1'b0;
        held_q     <= 1'b0;
        fast_q     <= 1'b0;
      end else begin
        state_q    <= state_d;
        count_q    <= count_d;
        interval_q <= interval_d;
        step_q     <= step_d;
        clean_q    <= clean_d;
        held_q     <= held_d;
        fast_q     <= fast_d;
      end
    end

    assign clean[g] = clean_q;
    assign held[g]  = held_q;
    assign fast[g]  = fast_q;
  end

endmodule

// File: tb/tb_key_repeat_debounce.sv
// Bench for key_repeat_debounce: run-length reference model checked every cycle, directed scenarios, random holds.
module tb_key_repeat_debounce;

  localparam int DELAY = 8;
  localparam int MAXS  = 2;
`ifdef DEBOUNCE_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] noisy = '0;
  logic [1:0] clean, held, fast;
  logic [0:0] noisy2 = '0;
  logic [0:0] clean2, held2, fast2;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  key_repeat_debounce #(.CHANNELS(2), .DELAY(DELAY), .MAX_STEPS(MAXS), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .noisy(noisy), .clean(clean), .held(held), .fast(fast)
  );

  key_repeat_debounce #(.CHANNELS(1), .DELAY(1), .MAX_STEPS(3), .CNT_W(4)) dut2 (
    .clk(clk), .reset(reset), .noisy(noisy2), .clean(clean2), .held(held2), .fast(fast2)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a press is a run of consecutive high samples. Pulse k (k=0,1,..)
  // lands where the run length hits next_p; the gap after pulse k is (DELAY>>min(k+1,MAXS))+1.
  int   run_n [2];
  int   next_p[2];
  int   npulse[2];
  logic exp_clean[2], exp_held[2], exp_fast[2];
  logic [1:0] pipe1 = '0, pipe2 = '0;

  always @(posedge clk) begin
    logic [1:0] s;
    int kb, sh;
`ifdef DEBOUNCE_SYNC_EN
    s = pipe2;
    if (reset) begin
      pipe1 = '0;
      pipe2 = '0;
    end else begin
      pipe2 = pipe1;
      pipe1 = noisy;
    end
`else
    s = noisy;
`endif
    for (int ch = 0; ch < 2; ch++) begin
      if (reset || !s[ch]) begin
        run_n[ch]     = 0;
        next_p[ch]    = DELAY + 1;
        npulse[ch]    = 0;
        exp_clean[ch] = 1'b0;
        exp_held[ch]  = 1'b0;
        exp_fast[ch]  = 1'b0;
      end else begin
        run_n[ch]++;
        kb = npulse[ch];
        exp_clean[ch] = 1'b0;
        if (run_n[ch] == next_p[ch]) begin
          exp_clean[ch] = 1'b1;
          npulse[ch]++;
          sh = (npulse[ch] < MAXS) ? npulse[ch] : MAXS;
          next_p[ch] = run_n[ch] + (DELAY >> sh) + 1;
        end
        exp_held[ch] = (npulse[ch] >= 1);
        exp_fast[ch] = exp_held[ch] && (kb >= MAXS);
      end
    end
  end

  // Single compare process, well after the edge where outputs and model have settled.
  always @(posedge clk) begin
    #2;
    for (int ch = 0; ch < 2; ch++) begin
      chk($sformatf("clean%0d", ch), int'(clean[ch]), int'(exp_clean[ch]));
      chk($sformatf("held%0d", ch), int'(held[ch]), int'(exp_held[ch]));
      chk($sformatf("fast%0d", ch), int'(fast[ch]), int'(exp_fast[ch]));
    end
  end

  // Drive one sample and return the outputs it produced after the capturing edge.
  task automatic drive_sample(input logic [1:0] v, output logic [1:0] c, output logic [1:0] f);
    @(negedge clk);
    noisy = v;
    @(posedge clk);
    #1;
    c = clean;
    f = fast;
  endtask

  initial begin
    logic [1:0] c, f;
    int pulses[$];
    int exp_p[$];
    int first0, first1, i;

    // Clock/reset
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_clean", int'(clean), 0);
    chk("rst_held", int'(held), 0);
    chk("rst_fast", int'(fast), 0);
    reset = 1'b0;

    // Long hold on channel 0 only
    exp_p = '{9, 14, 17, 20, 23, 26, 29};
    for (i = 1; i <= 30 + LAT; i++) begin
      drive_sample(2'b01, c, f);
      if (c[0]) pulses.push_back(i - LAT);
      if (i == 14 + LAT) chk("fast_before", int'(f[0]), 0);
      if (i == 15 + LAT) chk("fast_after", int'(f[0]), 1);
      if (c[1]) chk("idle_ch1_clean", int'(c[1]), 0);
    end
    chk("hold_npulses", pulses.size(), exp_p.size());
    for (int k = 0; k < exp_p.size() && k < pulses.size(); k++)
      chk($sformatf("hold_pulse%0d", k), pulses[k], exp_p[k]);
    repeat (4) drive_sample(2'b00, c, f);

    // Glitch restarts the full delay
    repeat (6) drive_sample(2'b01, c, f);
    drive_sample(2'b00, c, f);
    first0 = -1;
    for (i = 1; i <= 14 + LAT; i++) begin
      drive_sample(2'b01, c, f);
      if (c[0] && first0 < 0) first0 = i;
    end
    chk("glitch_first", first0, 9 + LAT);
    repeat (4) drive_sample(2'b00, c, f);

    // Two channels, second starts 3 samples later
    first0 = -1;
    first1 = -1;
    for (i = 1; i <= 20 + LAT; i++) begin
      drive_sample({(i > 3) ? 1'b1 : 1'b0, 1'b1}, c, f);
      if (c[0] && first0 < 0) first0 = i;
      if (c[1] && first1 < 0) first1 = i;
    end
    chk("indep_first0", first0, 9 + LAT);
    chk("indep_first1", first1, 12 + LAT);
    repeat (4) drive_sample(2'b00, c, f);

    // Reset mid-press, input still high afterwards
    repeat (12 + LAT) drive_sample(2'b01, c, f);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_clean", int'(clean), 0);
    chk("midrst_held", int'(held), 0);
    chk("midrst_fast", int'(fast), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    first0 = -1;
    for (i = 1; i <= 14 + LAT; i++) begin
      @(posedge clk);
      #1;
      if (clean[0] && first0 < 0) first0 = i;
    end
    chk("after_rst_first", first0, 9 + LAT);
    repeat (4) drive_sample(2'b00, c, f);

    // DELAY=1, MAX_STEPS=3 instance: pulse every sample from sample 2
    @(negedge clk);
    noisy2 = 1'b1;
    for (i = 1; i <= 10 + LAT; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("d1_sample%0d", i), int'(clean2[0]), (i >= 2 + LAT) ? 1 : 0);
    end
    @(negedge clk);
    noisy2 = 1'b0;

    // Random holds with occasional reset, checked by the model every cycle
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      for (int ch = 0; ch < 2; ch++)
        if ($urandom_range(15, 0) == 0) noisy[ch] = ~noisy[ch];
      reset = ($urandom_range(399, 0) == 0);
    end
    @(negedge clk);
    reset = 1'b0;
    noisy = '0;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
